elastic_pipe: RTL and testbench

Parametrised elastic pipeline register chain. It replaces the hard-wired inter-stage registers of the five-stage core with a DEPTH-deep chain of WIDTH-bit slots. Each slot carries a valid bit and moves under valid/ready backpressure. The chain also provides a global hold, per-slot flush and bubble compaction. Hazard logic observes per-slot occupancy through `stage_valid`.

---
 rtl/common_pkg.sv | 11 +
 rtl/pipe_slot.sv | 40 ++++
 rtl/elastic_pipe.sv | 96 +++++++++
 tb/tb_elastic_pipe.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/common_pkg.sv
// Shared core constants: pipeline stage indices and the
// depth used when the elastic chain replaces the inter-stage registers.
package common_pkg;

    localparam int IF_ID           = 0;
    localparam int ID_EX           = 1;
    localparam int EX_MEM          = 2;
    localparam int MEM_WB          = 3;
    localparam int CORE_PIPE_DEPTH = 4;

endpackage

// File: rtl/pipe_slot.sv
// One elastic slot: a valid bit plus payload register.
// Loads from its predecessor on a move, otherwise keeps data and drops a killed entry.
module pipe_slot
    import common_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             kill,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    output logic             valid,
    output logic             nxt_valid,
    output logic [WIDTH-1:0] data
);

    // next valid: take the incoming valid on a move, else survive unless killed
    always_comb begin
        nxt_valid = valid & ~kill;
        if (load) begin
            nxt_valid = src_valid;
        end
    end

    // slot register; payload only changes on a move
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            valid <= nxt_valid;
            if (load) begin
                data <= src_data;
            end
        end
    end

endmodule

// File: rtl/elastic_pipe.sv
// DEPTH-deep elastic register chain with valid/ready backpressure,
// global hold, per-slot flush and bubble compaction.
module elastic_pipe
    import common_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = CORE_PIPE_DEPTH,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             hold,
    input  logic [DEPTH-1:0] flush,
    output logic [DEPTH-1:0] stage_valid,
    output logic [CNT_W-1:0] count
);

    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] ev;
    logic [DEPTH-1:0] load;
    logic [DEPTH-1:0] src_valid;
    logic [DEPTH-1:0] nxt_valid;
    logic [DEPTH:0]   rdy;
    logic [WIDTH-1:0] data [DEPTH];
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] count_q;

    // ready chain from the output back to slot 0; an empty or
    // flushed slot passes ready through, which compacts bubbles
    always_comb begin
        ev         = valid & ~flush;
        rdy        = '0;
        rdy[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rdy[i] = ~ev[i] | rdy[i+1];
        end
        load         = rdy[DEPTH-1:0] & {DEPTH{~hold}};
        src_valid    = '0;
        src_valid[0] = in_valid;
        for (int i = 1; i < DEPTH; i++) begin
            src_valid[i] = ev[i-1];
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic [WIDTH-1:0] src_data;
        if (i == 0) begin : g_head
            assign src_data = in_data;
        end else begin : g_body
            assign src_data = data[i-1];
        end
        pipe_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .load     (load[i]),
            .kill     (flush[i]),
            .src_valid(src_valid[i]),
            .src_data (src_data),
            .valid    (valid[i]),
            .nxt_valid(nxt_valid[i]),
            .data     (data[i])
        );
    end

    // popcount of the next-state valid vector
    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_nxt = cnt_nxt + CNT_W'(nxt_valid[i]);
        end
    end

    // occupancy register, updated alongside the slot valids
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= cnt_nxt;
        end
    end

    assign in_ready    = rst & ~hold & rdy[0];
    assign out_valid   = ~hold & ev[DEPTH-1];
    assign out_data    = data[DEPTH-1];
    assign stage_valid = valid;
    assign count       = count_q;

endmodule

// File: tb/tb_elastic_pipe.sv
// Directed testbench for elastic_pipe (WIDTH=32, DEPTH=4).
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_elastic_pipe;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             hold;
    logic [DEPTH-1:0] flush;
    logic [DEPTH-1:0] stage_valid;
    logic [CNT_W-1:0] count;

    int checks;
    int errors;
    logic [WIDTH-1:0] got [$];

    elastic_pipe #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .hold       (hold),
        .flush      (flush),
        .stage_valid(stage_valid),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        in_valid = 1'b0;
        in_data  = '0;
        hold     = 1'b0;
        flush    = '0;
    endtask

    // run n cycles with out_ready=1, recording every handshake
    task automatic collect(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            idle();
            out_ready = 1'b1;
            #1;
            if (out_valid) got.push_back(out_data);
        end
    endtask

    task automatic fill4(input logic [WIDTH-1:0] base);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            idle();
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = base + WIDTH'(k);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        checks++;
        if (out_data !== 32'h0) begin
            errors++; $display("FAIL reset_out_data: got %h want 0", out_data);
        end
        checks++;
        if (stage_valid !== 4'b0000) begin
            errors++; $display("FAIL reset_stage_valid: got %b want 0000", stage_valid);
        end
        checks++;
        if (count !== 3'd0) begin
            errors++; $display("FAIL reset_count: got %0d want 0", count);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL release_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_fill();
        logic exp_v;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            idle();
            out_ready = 1'b1;
            in_valid  = (k < 4);
            in_data   = 32'h11 * (k + 1);
            #1;
            exp_v = (k >= 4) && (k < 8);
            checks++;
            if (out_valid !== exp_v) begin
                errors++; $display("FAIL fill_out_valid k=%0d: got %b want %b", k, out_valid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (out_data !== 32'h11 * (k - 3)) begin
                    errors++; $display("FAIL fill_out_data k=%0d: got %h want %h", k, out_data, 32'h11 * (k - 3));
                end
            end
            if (k < 4) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++; $display("FAIL fill_in_ready k=%0d: got %b want 1", k, in_ready);
                end
            end
            if (k == 4) begin
                checks++;
                if (count !== 3'd4) begin
                    errors++; $display("FAIL fill_count_peak: got %0d want 4", count);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            idle();
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = 32'hA0 + k;
            #1;
            checks++;
            if (in_ready !== (k < 4)) begin
                errors++; $display("FAIL bp_in_ready k=%0d: got %b want %b", k, in_ready, (k < 4));
            end
            if (k >= 4) begin
                checks++;
                if (count !== 3'd4) begin
                    errors++; $display("FAIL bp_count k=%0d: got %0d want 4", k, count);
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            idle();
            out_ready = 1'b1;
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'hA0 + k) begin
                errors++; $display("FAIL bp_drain k=%0d: got v=%b d=%h want v=1 d=%h", k, out_valid, out_data, 32'hA0 + k);
            end
            if (k == 0) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready);
                end
            end
        end
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        checks++;
        if (count !== 3'd0) begin
            errors++; $display("FAIL bp_empty_count: got %0d want 0", count);
        end
    endtask

    task automatic test_compaction();
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            idle();
            out_ready = 1'b0;
            in_valid  = (k == 0) || (k == 3);
            in_data   = (k == 0) ? 32'hC1 : 32'hC2;
            #1;
            if (k == 4) begin
                checks++;
                if (stage_valid !== 4'b1001) begin
                    errors++; $display("FAIL comp_sv_k4: got %b want 1001", stage_valid);
                end
            end
        end
        checks++;
        if (stage_valid !== 4'b1100) begin
            errors++; $display("FAIL comp_stage_valid: got %b want 1100", stage_valid);
        end
        checks++;
        if (count !== 3'd2) begin
            errors++; $display("FAIL comp_count: got %0d want 2", count);
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hC1) begin
            errors++; $display("FAIL comp_head: got v=%b d=%h want v=1 d=c1", out_valid, out_data);
        end
        got.delete();
        collect(4);
        checks++;
        if (got.size() != 2 || got[0] !== 32'hC1 || got[1] !== 32'hC2) begin
            errors++; $display("FAIL comp_drain: got n=%0d want C1,C2", got.size());
        end
    endtask

    task automatic test_flush();
        fill4(32'hD1);
        @(negedge clk);
        idle();
        out_ready = 1'b0;
        flush     = 4'b0110;
        #1;
        checks++;
        if (stage_valid !== 4'b1111) begin
            errors++; $display("FAIL flush_pre_sv: got %b want 1111", stage_valid);
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (count !== 3'd2) begin
            errors++; $display("FAIL flush_count: got %0d want 2", count);
        end
        checks++;
        if (stage_valid !== 4'b1010) begin
            errors++; $display("FAIL flush_sv: got %b want 1010", stage_valid);
        end
        got.delete();
        collect(6);
        checks++;
        if (got.size() != 2 || got[0] !== 32'hD1 || got[1] !== 32'hD4) begin
            errors++; $display("FAIL flush_drain: got n=%0d want D1,D4", got.size());
        end
    endtask

    task automatic test_hold();
        logic [3:0] exp_sv;
        fill4(32'hE1);
        for (int h = 0; h < 3; h++) begin
            @(negedge clk);
            idle();
            hold      = 1'b1;
            out_ready = 1'b1;
            in_valid  = 1'b1;
            in_data   = 32'hEE;
            flush     = (h == 1) ? 4'b0010 : 4'b0000;
            #1;
            exp_sv = (h == 2) ? 4'b1101 : 4'b1111;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                errors++; $display("FAIL hold_handshake h=%0d: got ov=%b ir=%b want 0 0", h, out_valid, in_ready);
            end
            checks++;
            if (stage_valid !== exp_sv) begin
                errors++; $display("FAIL hold_sv h=%0d: got %b want %b", h, stage_valid, exp_sv);
            end
        end
        checks++;
        if (count !== 3'd3) begin
            errors++; $display("FAIL hold_flush_count: got %0d want 3", count);
        end
        got.delete();
        collect(6);
        checks++;
        if (got.size() != 3 || got[0] !== 32'hE1 || got[1] !== 32'hE2 || got[2] !== 32'hE4) begin
            errors++; $display("FAIL hold_drain: got n=%0d want E1,E2,E4", got.size());
        end
    endtask

    task automatic test_back_to_back();
        fill4(32'h61);
        @(negedge clk);
        idle();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h65;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== 32'h61) begin
            errors++; $display("FAIL b2b_both: got ir=%b ov=%b d=%h want 1 1 61", in_ready, out_valid, out_data);
        end
        @(negedge clk);
        idle();
        out_ready = 1'b0;
        #1;
        checks++;
        if (count !== 3'd4 || stage_valid !== 4'b1111) begin
            errors++; $display("FAIL b2b_count: got c=%0d sv=%b want 4 1111", count, stage_valid);
        end
        got.delete();
        collect(5);
        checks++;
        if (got.size() != 4 || got[0] !== 32'h62 || got[1] !== 32'h63 || got[2] !== 32'h64 || got[3] !== 32'h65) begin
            errors++; $display("FAIL b2b_drain: got n=%0d want 62,63,64,65", got.size());
        end
    endtask

    task automatic test_midreset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            idle();
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = 32'hF1 + k;
        end
        @(negedge clk);
        idle();
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL mrst_in_ready: got %b want 0", in_ready);
        end
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h5A;
        #1;
        checks++;
        if (stage_valid !== 4'b0000 || count !== 3'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL mrst_clear: got sv=%b c=%0d ov=%b want 0000 0 0", stage_valid, count, out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL mrst_accept: got %b want 1", in_ready);
        end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            idle();
            out_ready = 1'b1;
            #1;
            checks++;
            if (out_valid !== (k == 4)) begin
                errors++; $display("FAIL mrst_latency k=%0d: got %b want %b", k, out_valid, (k == 4));
            end
        end
        checks++;
        if (out_data !== 32'h5A) begin
            errors++; $display("FAIL mrst_data: got %h want 5a", out_data);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_fill();
        test_backpressure();
        test_compaction();
        test_flush();
        test_hold();
        test_back_to_back();
        test_midreset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
